scpad_dram_xfer_engine: RTL and testbench
=========================================

Name: scpad_dram_xfer_engine

Overview:
- Parametrised row-transfer engine between one scratchpad backend and DRAM.
- Accepts one load or store command covering num_rows rows of num_cols elements. It splits each row into DRAM beats tagged {row, beat} and tracks out-of-order read responses in NUM_ROW_BUFS row buffers. It retires whole rows to the scratchpad in order.
- Stores: reads one SRAM row, then streams its beats to DRAM.
- Unlike the previous backend, only the beats a row actually needs are issued; there are no padding bursts.

Parameters:
- ROW_BYTES, 64: bytes per scratchpad row.
- BEAT_BYTES, 8: bytes per DRAM beat. BEATS = ROW_BYTES/BEAT_BYTES.
- ELEM_BYTES, 2: bytes per element. EPB = BEAT_BYTES/ELEM_BYTES.
- MAX_ROWS, 32: maximum rows per command. ROW_W = $clog2(MAX_ROWS), BEAT_W = $clog2(BEATS).
- NUM_ROW_BUFS, 2: load rows allowed in flight (power of 2, ≥1).
- DRAM_ADDR_W, 32: DRAM byte address width.
- SPAD_ADDR_W, 20: scratchpad byte address width.
- ID_W, 8: DRAM tag width (≥ ROW_W+BEAT_W).

Ports:
- clk, input, 1: clock.
- n_rst, input, 1: asynchronous active-low reset.
- cmd_valid, input, 1: command offered.
- cmd_ready, output, 1: engine idle, command accepted.
- cmd_write, input, 1: 1=store (SRAM to DRAM), 0=load.
- cmd_dram_addr, input, DRAM_ADDR_W: DRAM base, ROW_BYTES aligned.
- cmd_spad_addr, input, SPAD_ADDR_W: scratchpad base, ROW_BYTES aligned.
- cmd_num_rows, input, ROW_W+1: rows, 0..MAX_ROWS.
- cmd_num_cols, input, $clog2(ROW_BYTES/ELEM_BYTES)+1: elements per row.
- done, output, 1: one-cycle completion pulse.
- err, output, 1: sticky; unexpected or duplicate response tag.
- dram_req_valid/dram_req_ready, output/input, 1: DRAM request handshake.
- dram_req_write, output, 1: 1=write beat.
- dram_req_id, output, ID_W: zero-extended {row, beat}.
- dram_req_addr, output, DRAM_ADDR_W: beat address.
- dram_req_num_bytes, output, $clog2(BEAT_BYTES)+1: always BEAT_BYTES.
- dram_req_wdata, output, BEAT_BYTES*8: store beat data.
- dram_res_valid, input, 1: read response.
- dram_res_id, input, ID_W: response tag.
- dram_res_rdata, input, BEAT_BYTES*8: response data.
- sram_req_valid/sram_req_ready, output/input, 1: SRAM request handshake.
- sram_req_write, output, 1: 1=row write.
- sram_req_addr, output, SPAD_ADDR_W: row address.
- sram_req_row_id, output, ROW_W: row index within the command.
- sram_req_wdata, output, ROW_BYTES*8: row data.
- sram_res_valid, input, 1: SRAM read data valid.
- sram_res_rdata, input, ROW_BYTES*8: SRAM read data.

Behaviour:

Reset:
- All valids, done, err and data outputs are 0. The FSM is in IDLE and cmd_ready is 1.
- Reset mid-operation discards all buffers and counters. No request is re-issued after reset.

Command handling:
- cmd_ready = (state==IDLE). On cmd_valid&&cmd_ready, the command fields are latched.
- beats = ceil(num_cols/EPB). num_cols > ROW_BYTES/ELEM_BYTES saturates to BEATS.
- num_rows==0 or num_cols==0: go to DONE with no requests.

Addressing (DRAM_ADDR_W arithmetic, wraps silently):
- Beat address = base + row*ROW_BYTES + beat*BEAT_BYTES.
- Row scratchpad address = spad_base + row*ROW_BYTES.

FSM states: IDLE, LD_RUN, ST_SRD, ST_WAIT, ST_DWR, DONE.
- IDLE goes to LD_RUN or ST_SRD by cmd_write.
- DONE asserts done for 1 cycle, then returns to IDLE.

LD_RUN issue side:
- Issue pointer (irow, ibeat) and retire pointer rrow.
- Row irow may issue only while irow-rrow < NUM_ROW_BUFS.
- dram_req fields stay stable while valid&&!ready. The pointer advances on the handshake.
- ibeat wraps to 0 after beats-1.

LD_RUN response side:
- A response writes buffer[row % NUM_ROW_BUFS] beat slot and sets its valid bit.
- A response whose row is outside [rrow, irow], whose beat ≥ beats, or whose valid bit is already set: dropped, err is set.

LD_RUN retire side:
- When buffer[rrow%NUM_ROW_BUFS] has all beats valid, drive sram_req_valid=1, write=1 with the row data. Bytes at index ≥ num_cols*ELEM_BYTES are zero.
- On handshake: clear the valid bits and increment rrow.
- Issue, response and retire may all happen in the same cycle.
- A buffer freed by retire can be reused by issue in the next cycle, not the same one.
- rrow==num_rows goes to DONE.

Store path (one row at a time):
- ST_SRD: sram_req_valid=1, write=0, row address. On handshake go to ST_WAIT.
- ST_WAIT: on sram_res_valid latch the row and go to ST_DWR.
- ST_DWR: issue beats 0..beats-1 with write=1. wdata = row bytes [beat*BEAT_BYTES +: BEAT_BYTES].
- After the last beat handshake: row++. If row==num_rows go to DONE, else go to ST_SRD.
- No DRAM responses are expected in stores. A dram_res_valid during a store sets err.

Test Plan:
- Load, base 0x1000, rows=2, cols=10: DRAM reads at 0x1000/1008/1010/1040/1048/1050 with ids 0x00/01/02/08/09/0A. Then two SRAM writes, at spad 0x0 and 0x40, with bytes 20..63 zero. Then done pulses once.
- Load, rows=4, responses returned in reverse order, dram_req_ready=1: row 2 is not issued before row 0 retires. SRAM writes occur in row order 0,1,2,3.
- Load with a duplicate response id 0x01 and a stray id 0x18: err=1 and the data is not corrupted. With sram_req_ready held low 5 cycles, sram_req_valid and its data stay stable.
- Store, rows=1, cols=32, dram_req_ready toggling: one SRAM read, then 8 write beats at base+0..0x38 with wdata matching the slices. Each beat is held stable while stalled.
- rows=0 → done 1 cycle after accept, no requests. Reset asserted mid-load → all outputs 0 and cmd_ready=1 after release.

Source files
------------

// File: rtl/scpad_dram_xfer_engine.sv
// scpad_dram_xfer_engine: moves whole scratchpad rows to and from DRAM,
// splitting rows into tagged beats and retiring load rows in order.
module scpad_dram_xfer_engine #(
   parameter int ROW_BYTES    = 64,
   parameter int BEAT_BYTES   = 8,
   parameter int ELEM_BYTES   = 2,
   parameter int MAX_ROWS     = 32,
   parameter int NUM_ROW_BUFS = 2,
   parameter int DRAM_ADDR_W  = 32,
   parameter int SPAD_ADDR_W  = 20,
   parameter int ID_W         = 8,
   localparam int BEATS  = ROW_BYTES / BEAT_BYTES,
   localparam int EPB    = BEAT_BYTES / ELEM_BYTES,
   localparam int ROW_W  = $clog2(MAX_ROWS),
   localparam int BEAT_W = $clog2(BEATS),
   localparam int COLS_W = $clog2(ROW_BYTES / ELEM_BYTES) + 1,
   localparam int NB_W   = $clog2(BEAT_BYTES) + 1
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [DRAM_ADDR_W-1:0]   cmd_dram_addr,
   input  logic [SPAD_ADDR_W-1:0]   cmd_spad_addr,
   input  logic [ROW_W:0]           cmd_num_rows,
   input  logic [COLS_W-1:0]        cmd_num_cols,
   output logic                     done,
   output logic                     err,
   output logic                     dram_req_valid,
   input  logic                     dram_req_ready,
   output logic                     dram_req_write,
   output logic [ID_W-1:0]          dram_req_id,
   output logic [DRAM_ADDR_W-1:0]   dram_req_addr,
   output logic [NB_W-1:0]          dram_req_num_bytes,
   output logic [BEAT_BYTES*8-1:0]  dram_req_wdata,
   input  logic                     dram_res_valid,
   input  logic [ID_W-1:0]          dram_res_id,
   input  logic [BEAT_BYTES*8-1:0]  dram_res_rdata,
   output logic                     sram_req_valid,
   input  logic                     sram_req_ready,
   output logic                     sram_req_write,
   output logic [SPAD_ADDR_W-1:0]   sram_req_addr,
   output logic [ROW_W-1:0]         sram_req_row_id,
   output logic [ROW_BYTES*8-1:0]   sram_req_wdata,
   input  logic                     sram_res_valid,
   input  logic [ROW_BYTES*8-1:0]   sram_res_rdata
);

   localparam int ROW_ELEMS = ROW_BYTES / ELEM_BYTES;
   localparam int BEAT_BITS = BEAT_BYTES * 8;
   localparam int RB_W = (NUM_ROW_BUFS > 1) ? $clog2(NUM_ROW_BUFS) : 1;
   localparam logic [ROW_W:0] NBUF = (ROW_W+1)'(NUM_ROW_BUFS);

   typedef enum logic [2:0] {
      IDLE, LD_RUN, ST_SRD, ST_WAIT, ST_DWR, DONE
   } state_t;

   state_t state, nxt;

   logic [DRAM_ADDR_W-1:0] dbase;
   logic [SPAD_ADDR_W-1:0] sbase;
   logic [ROW_W:0]         nrows, irow, rrow;
   logic [COLS_W-1:0]      ncols;
   logic [BEAT_W:0]        nbeats;
   logic [BEAT_W-1:0]      ibeat;
   logic [ROW_BYTES*8-1:0] buf_data [NUM_ROW_BUFS];
   logic [BEATS-1:0]       buf_vld  [NUM_ROW_BUFS];

   logic [COLS_W-1:0]      cols_clip;
   logic [BEAT_W:0]        beats_calc;
   logic [RB_W-1:0]        rbuf, res_buf;
   logic [ROW_W-1:0]       res_row;
   logic [BEAT_W-1:0]      res_beat;
   logic [ROW_W:0]         res_row_x;
   logic [ROW_W:0]         srow_sel;
   logic                   res_ok, can_iss, ret_ok, last_beat;
   logic                   iss_fire, ret_fire;
   logic [BEATS-1:0]       beat_mask;
   logic [ROW_BYTES*8-1:0] byte_mask;
   logic [DRAM_ADDR_W-1:0] beat_addr;
   logic [SPAD_ADDR_W-1:0] row_saddr;

   assign cols_clip = (cmd_num_cols > COLS_W'(ROW_ELEMS)) ?
                      COLS_W'(ROW_ELEMS) : cmd_num_cols;
   assign beats_calc = (BEAT_W+1)'((cols_clip + COLS_W'(EPB-1)) / COLS_W'(EPB));

   assign rbuf      = RB_W'(rrow % NUM_ROW_BUFS);
   assign res_row   = dram_res_id[ROW_W+BEAT_W-1:BEAT_W];
   assign res_beat  = dram_res_id[BEAT_W-1:0];
   assign res_row_x = {1'b0, res_row};
   assign res_buf   = RB_W'(res_row % NUM_ROW_BUFS);

   // a response must target an open row window slot not yet filled
   assign res_ok = ((dram_res_id >> (ROW_W + BEAT_W)) == '0)
                && (res_row_x >= rrow) && (res_row_x <= irow)
                && ((res_row_x - rrow) < NBUF) && (res_row_x < nrows)
                && ({1'b0, res_beat} < nbeats)
                && !buf_vld[res_buf][res_beat];

   assign can_iss = (state == LD_RUN) && (irow < nrows)
                 && ((irow - rrow) < NBUF);
   assign ret_ok  = (state == LD_RUN) && (rrow < nrows)
                 && (&(buf_vld[rbuf] | ~beat_mask));
   assign last_beat = ({1'b0, ibeat} == nbeats - (BEAT_W+1)'(1));
   assign iss_fire  = dram_req_valid && dram_req_ready;
   assign ret_fire  = ret_ok && sram_req_ready;

   assign beat_addr = dbase
                    + DRAM_ADDR_W'(irow) * DRAM_ADDR_W'(ROW_BYTES)
                    + DRAM_ADDR_W'(ibeat) * DRAM_ADDR_W'(BEAT_BYTES);
   assign srow_sel  = (state == LD_RUN) ? rrow : irow;
   assign row_saddr = sbase + SPAD_ADDR_W'(srow_sel) * SPAD_ADDR_W'(ROW_BYTES);

   // which beats a row needs and which bytes of a row are live
   always_comb begin
      beat_mask = '0;
      byte_mask = '0;
      for (int i = 0; i < BEATS; i++)
         beat_mask[i] = (i < int'(nbeats));
      for (int i = 0; i < ROW_BYTES; i++)
         byte_mask[i*8 +: 8] = (i < int'(ncols) * ELEM_BYTES) ? 8'hFF : 8'h00;
   end

   // next state and request outputs
   always_comb begin
      nxt                = state;
      cmd_ready          = 1'b0;
      done               = 1'b0;
      dram_req_valid     = 1'b0;
      dram_req_write     = 1'b0;
      dram_req_id        = '0;
      dram_req_addr      = '0;
      dram_req_num_bytes = '0;
      dram_req_wdata     = '0;
      sram_req_valid     = 1'b0;
      sram_req_write     = 1'b0;
      sram_req_addr      = '0;
      sram_req_row_id    = '0;
      sram_req_wdata     = '0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_num_rows == '0 || cmd_num_cols == '0) nxt = DONE;
               else if (cmd_write)                          nxt = ST_SRD;
               else                                         nxt = LD_RUN;
            end
         end
         LD_RUN: begin
            if (can_iss) begin
               dram_req_valid     = 1'b1;
               dram_req_id        = ID_W'({irow[ROW_W-1:0], ibeat});
               dram_req_addr      = beat_addr;
               dram_req_num_bytes = NB_W'(BEAT_BYTES);
            end
            if (ret_ok) begin
               sram_req_valid  = 1'b1;
               sram_req_write  = 1'b1;
               sram_req_addr   = row_saddr;
               sram_req_row_id = rrow[ROW_W-1:0];
               sram_req_wdata  = buf_data[rbuf] & byte_mask;
            end
            if (rrow == nrows) nxt = DONE;
         end
         ST_SRD: begin
            sram_req_valid  = 1'b1;
            sram_req_addr   = row_saddr;
            sram_req_row_id = irow[ROW_W-1:0];
            if (sram_req_ready) nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (sram_res_valid) nxt = ST_DWR;
         end
         ST_DWR: begin
            dram_req_valid     = 1'b1;
            dram_req_write     = 1'b1;
            dram_req_id        = ID_W'({irow[ROW_W-1:0], ibeat});
            dram_req_addr      = beat_addr;
            dram_req_num_bytes = NB_W'(BEAT_BYTES);
            dram_req_wdata     = buf_data[0][int'(ibeat)*BEAT_BITS +: BEAT_BITS];
            if (dram_req_ready && last_beat)
               nxt = (irow + (ROW_W+1)'(1) == nrows) ? DONE : ST_SRD;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // command latch, pointers, row buffers and sticky error
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         dbase  <= '0;
         sbase  <= '0;
         nrows  <= '0;
         ncols  <= '0;
         nbeats <= '0;
         irow   <= '0;
         ibeat  <= '0;
         rrow   <= '0;
         err    <= 1'b0;
         for (int i = 0; i < NUM_ROW_BUFS; i++) begin
            buf_data[i] <= '0;
            buf_vld[i]  <= '0;
         end
      end else begin
         state <= nxt;
         if (cmd_ready && cmd_valid) begin
            dbase  <= cmd_dram_addr;
            sbase  <= cmd_spad_addr;
            nrows  <= cmd_num_rows;
            ncols  <= cols_clip;
            nbeats <= beats_calc;
            irow   <= '0;
            ibeat  <= '0;
            rrow   <= '0;
            for (int i = 0; i < NUM_ROW_BUFS; i++)
               buf_vld[i] <= '0;
         end
         if (iss_fire) begin
            if (last_beat) begin
               ibeat <= '0;
               irow  <= irow + (ROW_W+1)'(1);
            end else begin
               ibeat <= ibeat + BEAT_W'(1);
            end
         end
         if (ret_fire) begin
            buf_vld[rbuf] <= '0;
            rrow          <= rrow + (ROW_W+1)'(1);
         end
         if (dram_res_valid) begin
            if (state == LD_RUN && res_ok) begin
               buf_data[res_buf][int'(res_beat)*BEAT_BITS +: BEAT_BITS] <= dram_res_rdata;
               buf_vld[res_buf][res_beat] <= 1'b1;
            end else begin
               err <= 1'b1;
            end
         end
         if (state == ST_WAIT && sram_res_valid)
            buf_data[0] <= sram_res_rdata;
      end
   end

endmodule

// File: tb/tb_scpad_dram_xfer_engine.sv
// tb_scpad_dram_xfer_engine: directed loads, stores, stalls, bad tags,
// empty commands and mid-load reset against hand-computed values.
module tb_scpad_dram_xfer_engine;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         cmd_valid, cmd_ready, cmd_write;
   logic [31:0]  cmd_dram_addr;
   logic [19:0]  cmd_spad_addr;
   logic [5:0]   cmd_num_rows;
   logic [5:0]   cmd_num_cols;
   logic         done, err;
   logic         dram_req_valid, dram_req_ready, dram_req_write;
   logic [7:0]   dram_req_id;
   logic [31:0]  dram_req_addr;
   logic [3:0]   dram_req_num_bytes;
   logic [63:0]  dram_req_wdata;
   logic         dram_res_valid;
   logic [7:0]   dram_res_id;
   logic [63:0]  dram_res_rdata;
   logic         sram_req_valid, sram_req_ready, sram_req_write;
   logic [19:0]  sram_req_addr;
   logic [4:0]   sram_req_row_id;
   logic [511:0] sram_req_wdata;
   logic         sram_res_valid;
   logic [511:0] sram_res_rdata;

   always #5 clk = ~clk;

   scpad_dram_xfer_engine dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_write          (cmd_write),
      .cmd_dram_addr      (cmd_dram_addr),
      .cmd_spad_addr      (cmd_spad_addr),
      .cmd_num_rows       (cmd_num_rows),
      .cmd_num_cols       (cmd_num_cols),
      .done               (done),
      .err                (err),
      .dram_req_valid     (dram_req_valid),
      .dram_req_ready     (dram_req_ready),
      .dram_req_write     (dram_req_write),
      .dram_req_id        (dram_req_id),
      .dram_req_addr      (dram_req_addr),
      .dram_req_num_bytes (dram_req_num_bytes),
      .dram_req_wdata     (dram_req_wdata),
      .dram_res_valid     (dram_res_valid),
      .dram_res_id        (dram_res_id),
      .dram_res_rdata     (dram_res_rdata),
      .sram_req_valid     (sram_req_valid),
      .sram_req_ready     (sram_req_ready),
      .sram_req_write     (sram_req_write),
      .sram_req_addr      (sram_req_addr),
      .sram_req_row_id    (sram_req_row_id),
      .sram_req_wdata     (sram_req_wdata),
      .sram_res_valid     (sram_res_valid),
      .sram_res_rdata     (sram_res_rdata)
   );

   int           cyc = 0;
   int           done_cnt = 0;
   logic         dq_wr[$];
   logic [7:0]   dq_id[$];
   logic [31:0]  dq_addr[$];
   logic [3:0]   dq_nb[$];
   logic [63:0]  dq_wd[$];
   int           dq_cyc[$];
   logic         sq_wr[$];
   logic [19:0]  sq_addr[$];
   logic [4:0]   sq_row[$];
   logic [511:0] sq_wd[$];
   int           sq_cyc[$];
   int           dstab_n = 0, dstab_bad = 0;
   int           sstab_n = 0, sstab_bad = 0;
   logic         pdv = 1'b0, pdr = 1'b0, psv = 1'b0, psr = 1'b0;
   logic [108:0] pd = '0;
   logic [537:0] ps = '0;
   logic [108:0] cd;
   logic [537:0] cs;

   assign cd = {dram_req_write, dram_req_id, dram_req_addr,
                dram_req_num_bytes, dram_req_wdata};
   assign cs = {sram_req_write, sram_req_addr, sram_req_row_id, sram_req_wdata};

   // handshake log and stall-stability tracking, away from the rising edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (dram_req_valid && dram_req_ready) begin
         dq_wr.push_back(dram_req_write);
         dq_id.push_back(dram_req_id);
         dq_addr.push_back(dram_req_addr);
         dq_nb.push_back(dram_req_num_bytes);
         dq_wd.push_back(dram_req_wdata);
         dq_cyc.push_back(cyc);
      end
      if (sram_req_valid && sram_req_ready) begin
         sq_wr.push_back(sram_req_write);
         sq_addr.push_back(sram_req_addr);
         sq_row.push_back(sram_req_row_id);
         sq_wd.push_back(sram_req_wdata);
         sq_cyc.push_back(cyc);
      end
      if (pdv && !pdr && dram_req_valid) begin
         dstab_n <= dstab_n + 1;
         if (cd !== pd) dstab_bad <= dstab_bad + 1;
      end
      if (psv && !psr && sram_req_valid) begin
         sstab_n <= sstab_n + 1;
         if (cs !== ps) sstab_bad <= sstab_bad + 1;
      end
      pdv <= dram_req_valid;
      pdr <= dram_req_ready;
      pd  <= cd;
      psv <= sram_req_valid;
      psr <= sram_req_ready;
      ps  <= cs;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] dat(input logic [7:0] id);
      return {8{id ^ 8'hA5}} + 64'h0706050403020100;
   endfunction

   function automatic logic [511:0] exp_row(input int r, input int nb,
                                            input int nbytes);
      logic [511:0] v = '0;
      for (int b = 0; b < nb; b++) v[b*64 +: 64] = dat(8'(r*8 + b));
      for (int i = nbytes; i < 64; i++) v[i*8 +: 8] = 8'h00;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      tick();
      tick();
      n_rst = 1'b1;
      tick();
   endtask

   task automatic send_cmd(input logic w, input logic [31:0] da,
                           input logic [19:0] sa, input logic [5:0] r,
                           input logic [5:0] c);
      cmd_valid     = 1'b1;
      cmd_write     = w;
      cmd_dram_addr = da;
      cmd_spad_addr = sa;
      cmd_num_rows  = r;
      cmd_num_cols  = c;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic send_res(input logic [7:0] id, input logic [63:0] d);
      dram_res_valid = 1'b1;
      dram_res_id    = id;
      dram_res_rdata = d;
      tick();
      dram_res_valid = 1'b0;
   endtask

   task automatic wait_dq(input int n, input string tag);
      int k = 0;
      while (dq_id.size() < n && k < 200) begin
         tick();
         k++;
      end
      chk(tag, dq_id.size() >= n, 1'b1);
   endtask

   task automatic wait_done(input int d0, input string tag);
      int k = 0;
      while (done_cnt == d0 && k < 300) begin
         tick();
         k++;
      end
      chk(tag, done_cnt > d0, 1'b1);
   endtask

   task automatic auto_rsp(input int ix0, input int d0, input string tag);
      int ix = ix0;
      int k = 0;
      while (done_cnt == d0 && k < 300) begin
         if (ix < dq_id.size()) begin
            dram_res_valid = 1'b1;
            dram_res_id    = dq_id[ix];
            dram_res_rdata = dat(dq_id[ix]);
            ix++;
         end else begin
            dram_res_valid = 1'b0;
         end
         tick();
         k++;
      end
      dram_res_valid = 1'b0;
      chk(tag, done_cnt > d0, 1'b1);
   endtask

   initial begin
      logic [31:0]  ea [6] = '{32'h1000, 32'h1008, 32'h1010,
                               32'h1040, 32'h1048, 32'h1050};
      logic [7:0]   ei [6] = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h09, 8'h0A};
      logic [511:0] srow;
      int d0, s0, dn0, n0, b0, k;
      bit sent;

      for (int i = 0; i < 64; i++) srow[i*8 +: 8] = 8'(i*3 + 1);
      cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_dram_addr = '0; cmd_spad_addr = '0;
      cmd_num_rows = '0; cmd_num_cols = '0;
      dram_req_ready = 1'b0; dram_res_valid = 1'b0;
      dram_res_id = '0; dram_res_rdata = '0;
      sram_req_ready = 1'b0; sram_res_valid = 1'b0; sram_res_rdata = '0;
      do_reset();

      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_dram_valid", dram_req_valid, 1'b0);
      chk("rst_sram_valid", sram_req_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);

      // load: 2 rows x 10 cols -> 3 beats per row, bytes 20..63 zero
      dram_req_ready = 1'b1;
      sram_req_ready = 1'b1;
      d0 = dq_id.size(); s0 = sq_wr.size(); dn0 = done_cnt;
      send_cmd(1'b0, 32'h1000, 20'h0, 6'd2, 6'd10);
      auto_rsp(d0, dn0, "t1_timeout");
      repeat (3) tick();
      chk("t1_nreq", dq_id.size() - d0, 6);
      for (int i = 0; i < 6; i++) begin
         chk("t1_addr", dq_addr[d0+i], ea[i]);
         chk("t1_id", dq_id[d0+i], ei[i]);
         chk("t1_wr", dq_wr[d0+i], 1'b0);
      end
      chk("t1_nbytes", dq_nb[d0], 4'd8);
      chk("t1_nsram", sq_wr.size() - s0, 2);
      for (int r = 0; r < 2; r++) begin
         chk("t1_saddr", sq_addr[s0+r], 20'(r*64));
         chk("t1_srow", sq_row[s0+r], 5'(r));
         chk("t1_swr", sq_wr[s0+r], 1'b1);
         chk("t1_sdata", sq_wd[s0+r], exp_row(r, 3, 20));
         chk("t1_zero", sq_wd[s0+r] >> 160, 512'd0);
      end
      chk("t1_done_once", done_cnt - dn0, 1);
      chk("t1_err", err, 1'b0);

      // load: 4 rows x 8 cols, responses in reverse order per window
      d0 = dq_id.size(); s0 = sq_wr.size(); dn0 = done_cnt;
      send_cmd(1'b0, 32'h2000, 20'h100, 6'd4, 6'd8);
      repeat (6) tick();
      chk("t2_window", dq_id.size() - d0, 4);
      send_res(8'h09, dat(8'h09));
      send_res(8'h08, dat(8'h08));
      send_res(8'h01, dat(8'h01));
      send_res(8'h00, dat(8'h00));
      wait_dq(d0 + 8, "t2_issue_timeout");
      repeat (2) tick();
      send_res(8'h19, dat(8'h19));
      send_res(8'h18, dat(8'h18));
      send_res(8'h11, dat(8'h11));
      send_res(8'h10, dat(8'h10));
      wait_done(dn0, "t2_timeout");
      chk("t2_id4", dq_id[d0+4], 8'h10);
      chk("t2_id6", dq_id[d0+6], 8'h18);
      chk("t2_row2_after_ret0", dq_cyc[d0+4] > sq_cyc[s0], 1'b1);
      chk("t2_nsram", sq_wr.size() - s0, 4);
      for (int r = 0; r < 4; r++) begin
         chk("t2_srow", sq_row[s0+r], 5'(r));
         chk("t2_saddr", sq_addr[s0+r], 20'(256 + r*64));
         chk("t2_sdata", sq_wd[s0+r], exp_row(r, 2, 16));
      end
      chk("t2_err", err, 1'b0);

      // load with duplicate and stray tags, SRAM stalled
      do_reset();
      dram_req_ready = 1'b1;
      sram_req_ready = 1'b0;
      d0 = dq_id.size(); s0 = sq_wr.size(); dn0 = done_cnt;
      n0 = sstab_n; b0 = sstab_bad;
      send_cmd(1'b0, 32'h3000, 20'h200, 6'd2, 6'd8);
      wait_dq(d0 + 4, "t3_issue_timeout");
      send_res(8'h00, dat(8'h00));
      send_res(8'h01, dat(8'h01));
      send_res(8'h01, ~dat(8'h01));
      send_res(8'h18, 64'hDEAD_BEEF_0BAD_F00D);
      send_res(8'h08, dat(8'h08));
      send_res(8'h09, dat(8'h09));
      tick();
      chk("t3_err", err, 1'b1);
      chk("t3_sv0", sram_req_valid, 1'b1);
      chk("t3_row0", sram_req_row_id, 5'd0);
      chk("t3_data0", sram_req_wdata, exp_row(0, 2, 16));
      repeat (5) tick();
      chk("t3_sv5", sram_req_valid, 1'b1);
      chk("t3_data5", sram_req_wdata, exp_row(0, 2, 16));
      sram_req_ready = 1'b1;
      wait_done(dn0, "t3_timeout");
      chk("t3_nsram", sq_wr.size() - s0, 2);
      chk("t3_sd0", sq_wd[s0], exp_row(0, 2, 16));
      chk("t3_sd1", sq_wd[s0+1], exp_row(1, 2, 16));
      chk("t3_stable", sstab_bad - b0, 0);
      chk("t3_stalls", (sstab_n - n0) >= 5, 1'b1);

      // store: 1 row x 32 cols, DRAM ready toggling
      do_reset();
      sram_req_ready = 1'b1;
      d0 = dq_id.size(); s0 = sq_wr.size(); dn0 = done_cnt;
      n0 = dstab_n; b0 = dstab_bad;
      send_cmd(1'b1, 32'h4000, 20'h300, 6'd1, 6'd32);
      sent = 1'b0;
      k = 0;
      while (done_cnt == dn0 && k < 300) begin
         dram_req_ready = k[0];
         if (!sent && sq_wr.size() > s0) begin
            sram_res_valid = 1'b1;
            sram_res_rdata = srow;
            sent = 1'b1;
         end else begin
            sram_res_valid = 1'b0;
         end
         tick();
         k++;
      end
      sram_res_valid = 1'b0;
      chk("t4_timeout", done_cnt > dn0, 1'b1);
      chk("t4_nsram", sq_wr.size() - s0, 1);
      chk("t4_swr", sq_wr[s0], 1'b0);
      chk("t4_saddr", sq_addr[s0], 20'h300);
      chk("t4_nreq", dq_id.size() - d0, 8);
      for (int b = 0; b < 8; b++) begin
         chk("t4_wr", dq_wr[d0+b], 1'b1);
         chk("t4_addr", dq_addr[d0+b], 32'h4000 + 32'(b*8));
         chk("t4_id", dq_id[d0+b], 8'(b));
         chk("t4_wdata", dq_wd[d0+b], srow[b*64 +: 64]);
      end
      chk("t4_stable", dstab_bad - b0, 0);
      chk("t4_stalls", (dstab_n - n0) > 0, 1'b1);
      chk("t4_err", err, 1'b0);

      // empty commands: rows=0 and cols=0
      dram_req_ready = 1'b1;
      d0 = dq_id.size(); s0 = sq_wr.size();
      send_cmd(1'b0, 32'h5000, 20'h0, 6'd0, 6'd8);
      chk("t5_done", done, 1'b1);
      tick();
      chk("t5_done_off", done, 1'b0);
      chk("t5_ready", cmd_ready, 1'b1);
      send_cmd(1'b1, 32'h5000, 20'h0, 6'd3, 6'd0);
      chk("t5_done_c0", done, 1'b1);
      tick();
      chk("t5_noreq", dq_id.size() - d0, 0);
      chk("t5_nosram", sq_wr.size() - s0, 0);

      // reset in the middle of a load
      send_cmd(1'b0, 32'h6000, 20'h0, 6'd4, 6'd32);
      repeat (3) tick();
      n_rst = 1'b0;
      #1;
      chk("t6_dv", dram_req_valid, 1'b0);
      chk("t6_sv", sram_req_valid, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_err", err, 1'b0);
      chk("t6_daddr", dram_req_addr, 32'h0);
      chk("t6_sdata", sram_req_wdata, 512'h0);
      tick();
      n_rst = 1'b1;
      tick();
      chk("t6_ready", cmd_ready, 1'b1);
      d0 = dq_id.size();
      repeat (5) tick();
      chk("t6_noreissue", dq_id.size() - d0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
